// File: rtl/sistema_keys_pkg.sv
// Shared constants for the key input peripheral: register map and parameter defaults.
package sistema_keys_pkg;

   // Avalon-MM word addresses of the register file
   localparam logic [1:0] ADDR_DATA        = 2'd0;
   localparam logic [1:0] ADDR_DIRECTION   = 2'd1;
   localparam logic [1:0] ADDR_IRQMASK     = 2'd2;
   localparam logic [1:0] ADDR_EDGECAPTURE = 2'd3;

   // Default geometry: four keys, 1 ms debounce at 50 MHz
   localparam int unsigned DEF_WIDTH           = 4;
   localparam int unsigned DEF_DEBOUNCE_CYCLES = 50000;

endpackage

// File: rtl/sistema_keys_in_debounce.sv
// Single-key conditioner: 2-flop synchronizer, saturating-free debounce counter and
// stable-level flop. Also flags the edge on which a press (1->0) is accepted.
module key_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
   input  logic i_clk,
   input  logic i_reset_n,
   input  logic i_key,
   output logic o_stable,
   output logic o_press
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   // Counter tops out here; the acceptance edge resets it, so it never wraps
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             r_meta;
   logic             r_sync;
   logic             r_stable;
   logic [CNT_W-1:0] r_cnt;
   logic             w_diff;
   logic             w_accept;

   assign w_diff   = r_sync ^ r_stable;
   assign w_accept = w_diff && (r_cnt == CNT_LAST);

   // Synchronize the asynchronous key level; reset to the released level
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_meta <= 1'b1;
         r_sync <= 1'b1;
      end else begin
         r_meta <= i_key;
         r_sync <= r_meta;
      end
   end

   // Count consecutive differing cycles; accept the new level on the Nth one
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_cnt    <= '0;
         r_stable <= 1'b1;
      end else if (!w_diff) begin
         r_cnt    <= '0;
      end else if (w_accept) begin
         r_cnt    <= '0;
         r_stable <= r_sync;
      end else begin
         r_cnt    <= r_cnt + 1'b1;
      end
   end

   assign o_stable = r_stable;
   // Accepting a change while stable is high means the key goes to pressed
   assign o_press  = w_accept & r_stable;

endmodule

// File: rtl/sistema_keys_in.sv
// Avalon-MM key input peripheral: per-key debounce, DATA/DIRECTION/IRQMASK/EDGECAPTURE
// registers, press edge capture and a level interrupt.
module sistema_keys_in
   import sistema_keys_pkg::*;
#(
   parameter int unsigned WIDTH           = DEF_WIDTH,
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   logic [WIDTH-1:0] w_stable;
   logic [WIDTH-1:0] w_press;
   logic [WIDTH-1:0] w_clr;
   logic [WIDTH-1:0] r_irqmask;
   logic [WIDTH-1:0] r_edgecap;
   logic             w_wr_mask;
   logic             w_wr_edge;
   logic             w_unused_wdata;

   for (genvar g = 0; g < WIDTH; g++) begin : g_key
      key_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
         .i_clk    (clk),
         .i_reset_n(reset_n),
         .i_key    (in_port[g]),
         .o_stable (w_stable[g]),
         .o_press  (w_press[g])
      );
   end

   assign w_wr_mask = chipselect && !write_n && (address == ADDR_IRQMASK);
   assign w_wr_edge = chipselect && !write_n && (address == ADDR_EDGECAPTURE);
   assign w_clr     = w_wr_edge ? writedata[WIDTH-1:0] : '0;
   // Only the low WIDTH data bits are meaningful
   assign w_unused_wdata = ^writedata;

   // Interrupt mask register
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_irqmask <= '0;
      end else if (w_wr_mask) begin
         r_irqmask <= writedata[WIDTH-1:0];
      end
   end

   // Press capture with write-1-to-clear; a press on the same edge beats the clear
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_edgecap <= '0;
      end else begin
         r_edgecap <= (r_edgecap & ~w_clr) | w_press;
      end
   end

   // Zero-latency read mux, free of side effects
   always_comb begin
      readdata = '0;
      unique case (address)
         ADDR_DATA:        readdata = 32'(w_stable);
         ADDR_DIRECTION:   readdata = '0;
         ADDR_IRQMASK:     readdata = 32'(r_irqmask);
         ADDR_EDGECAPTURE: readdata = 32'(r_edgecap);
         default:          readdata = '0;
      endcase
   end

   assign irq = |(r_edgecap & r_irqmask);

endmodule
